// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Multiplexed N-digit common-anode 7-segment driver with
//            frame-synchronous double buffering, blanking, LZ suppression, blink.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 3,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 50,
    parameter int HEX_MODE     = 0
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              load,
    input  logic [4*NUM_DIGITS-1:0]                           bcd_in,
    input  logic [NUM_DIGITS-1:0]                             blank_mask,
    input  logic                                              lz_suppress,
    input  logic                                              blink_en,
    output logic [6:0]                                        seg,
    output logic [NUM_DIGITS-1:0]                             an,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                              frame_tick
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] C_SEG_OFF = 7'b1111111;

    logic [CNT_W-1:0]        r_refresh_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic                    r_shadow_lz;
    logic [4*NUM_DIGITS-1:0] r_disp_bcd;
    logic [NUM_DIGITS-1:0]   r_disp_blank;
    logic                    r_disp_lz;
    logic                    r_pending;
    logic [BLINK_W-1:0]      r_blink_cnt;
    logic                    r_blink_phase;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_tick;

    logic                    w_tc;
    logic                    w_last;
    logic                    w_wrap;
    logic [3:0]              w_nibble;
    logic                    w_mask_bit;
    logic                    w_upper_zero;
    logic                    w_lz_dark;
    logic [6:0]              w_seg_dec;
    logic                    w_dark;
    logic [NUM_DIGITS-1:0]   w_an_sel;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (HEX_MODE == 0 && v > 4'd9) begin
            s = C_SEG_OFF;
        end
        return s;
    endfunction

    assign w_tc   = (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_last = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_wrap = w_tc & w_last;

    // Select the current digit and find whether it and everything above it is zero.
    always_comb begin
        w_nibble     = 4'd0;
        w_mask_bit   = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nibble   = r_disp_bcd[4*i +: 4];
                w_mask_bit = r_disp_blank[i];
            end
            if (i >= int'(r_digit_idx) && r_disp_bcd[4*i +: 4] != 4'd0) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_lz_dark = r_disp_lz & (r_digit_idx != '0) & w_upper_zero;
    assign w_seg_dec = decode(w_nibble);
    // blink_en is used live so that dropping it relights the display on the next edge.
    assign w_dark    = w_mask_bit | w_lz_dark | (blink_en & r_blink_phase)
                     | (w_seg_dec == C_SEG_OFF);
    assign w_an_sel  = ~(NUM_DIGITS'(1) << r_digit_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt  <= '0;
            r_digit_idx    <= '0;
            r_shadow_bcd   <= '0;
            r_shadow_blank <= '0;
            r_shadow_lz    <= 1'b0;
            r_disp_bcd     <= '0;
            r_disp_blank   <= '0;
            r_disp_lz      <= 1'b0;
            r_pending      <= 1'b0;
            r_blink_cnt    <= '0;
            r_blink_phase  <= 1'b0;
            r_seg          <= C_SEG_OFF;
            r_an           <= '1;
            r_frame_tick   <= 1'b0;
        end else begin
            r_frame_tick <= w_wrap;

            if (w_tc) begin
                r_refresh_cnt <= '0;
                r_digit_idx   <= w_last ? '0 : r_digit_idx + IDX_W'(1);
            end else begin
                r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
            end

            // The shadow moves before a same-edge load overwrites it.
            if (w_wrap && r_pending) begin
                r_disp_bcd   <= r_shadow_bcd;
                r_disp_blank <= r_shadow_blank;
                r_disp_lz    <= r_shadow_lz;
            end

            if (load) begin
                r_shadow_bcd   <= bcd_in;
                r_shadow_blank <= blank_mask;
                r_shadow_lz    <= lz_suppress;
                r_pending      <= 1'b1;
            end else if (w_wrap) begin
                r_pending      <= 1'b0;
            end

            if (!blink_en) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b0;
            end else if (w_wrap) begin
                if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
                end
            end

            r_seg <= w_dark ? C_SEG_OFF : w_seg_dec;
            r_an  <= w_dark ? '1 : w_an_sel;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign digit_idx  = r_digit_idx;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Random and directed stimulus against a timing-arithmetic model,
//            driving a decimal-mode and a hex-mode instance in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N  = 3;
    localparam int R  = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [11:0] bcd_in;
    logic [2:0]  blank_mask;
    logic        lz_suppress;
    logic        blink_en;

    logic [6:0]  seg0, seg1;
    logic [2:0]  an0, an1;
    logic [1:0]  idx0, idx1;
    logic        tick0, tick1;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF), .HEX_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .blank_mask(blank_mask),
        .lz_suppress(lz_suppress), .blink_en(blink_en), .seg(seg0), .an(an0),
        .digit_idx(idx0), .frame_tick(tick0));

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF), .HEX_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .blank_mask(blank_mask),
        .lz_suppress(lz_suppress), .blink_en(blink_en), .seg(seg1), .an(an1),
        .digit_idx(idx1), .frame_tick(tick1));

    always #5 clk = ~clk;

    logic [6:0] tab [16];
    initial begin
        tab[0]  = 7'b0000001; tab[1]  = 7'b1001111; tab[2]  = 7'b0010010; tab[3]  = 7'b0000110;
        tab[4]  = 7'b1001100; tab[5]  = 7'b0100100; tab[6]  = 7'b0100000; tab[7]  = 7'b0001111;
        tab[8]  = 7'b0000000; tab[9]  = 7'b0000100; tab[10] = 7'b0001000; tab[11] = 7'b1100000;
        tab[12] = 7'b0110001; tab[13] = 7'b1000010; tab[14] = 7'b0110000; tab[15] = 7'b0111000;
    end

    function automatic logic [6:0] dec(input int v, input int hex);
        if (v < 10 || hex != 0) return tab[v];
        return 7'h7F;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: edges since reset release give scan position and frame boundaries directly.
    int         m_k, m_nw, m_pending;
    int         m_sh_bcd, m_sh_mask, m_sh_lz;
    int         m_dp_bcd, m_dp_mask, m_dp_lz;
    int         m_pos, m_nib;
    bit         m_top_zero, m_dark_c, m_dark, m_wrap;
    logic [6:0] m_s;
    logic [6:0] exp_seg [2];
    logic [2:0] exp_an  [2];
    logic       exp_tick;
    logic [1:0] exp_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_nw = 0; m_pending = 0;
            m_sh_bcd = 0; m_sh_mask = 0; m_sh_lz = 0;
            m_dp_bcd = 0; m_dp_mask = 0; m_dp_lz = 0;
            for (int h = 0; h < 2; h++) begin
                exp_seg[h] = 7'h7F;
                exp_an[h]  = 3'b111;
            end
            exp_tick = 1'b0;
            exp_idx  = 2'd0;
        end else begin
            m_pos      = (m_k / R) % N;
            m_nib      = (m_dp_bcd >> (4 * m_pos)) & 15;
            m_top_zero = ((m_dp_bcd >> (4 * m_pos)) == 0);
            m_dark_c   = (((m_dp_mask >> m_pos) & 1) != 0)
                       || (m_dp_lz != 0 && m_pos != 0 && m_top_zero)
                       || (blink_en && ((m_nw / BF) % 2 == 1));
            for (int h = 0; h < 2; h++) begin
                m_s        = dec(m_nib, h);
                m_dark     = m_dark_c || (m_s == 7'h7F);
                exp_seg[h] = m_dark ? 7'h7F : m_s;
                exp_an[h]  = m_dark ? 3'b111 : ~(3'b001 << m_pos);
            end
            m_k++;
            m_wrap   = ((m_k % (R * N)) == 0);
            exp_tick = m_wrap;
            exp_idx  = 2'((m_k / R) % N);
            if (m_wrap && m_pending != 0) begin
                m_dp_bcd = m_sh_bcd; m_dp_mask = m_sh_mask; m_dp_lz = m_sh_lz;
                m_pending = 0;
            end
            if (load) begin
                m_sh_bcd = int'(bcd_in); m_sh_mask = int'(blank_mask); m_sh_lz = int'(lz_suppress);
                m_pending = 1;
            end
            if (!blink_en) m_nw = 0;
            else if (m_wrap) m_nw++;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("seg0", 32'(seg0), 32'(exp_seg[0]));
            chk("an0", 32'(an0), 32'(exp_an[0]));
            chk("seg1", 32'(seg1), 32'(exp_seg[1]));
            chk("an1", 32'(an1), 32'(exp_an[1]));
            chk("idx0", 32'(idx0), 32'(exp_idx));
            chk("idx1", 32'(idx1), 32'(exp_idx));
            chk("tick0", 32'(tick0), 32'(exp_tick));
            chk("tick1", 32'(tick1), 32'(exp_tick));
        end
    end

    task automatic do_load(input logic [11:0] v, input logic [2:0] m, input logic lz);
        @(negedge clk);
        bcd_in = v; blank_mask = m; lz_suppress = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic show(input logic [11:0] v, input logic [2:0] m, input logic lz);
        do_load(v, m, lz);
        repeat (26) @(negedge clk);
    endtask

    task automatic check_digit(input string name, input int sel, input logic [2:0] pat,
                               input logic [6:0] exp_s);
        bit found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if ((sel == 0 ? an0 : an1) == pat) found = 1'b1;
        end
        if (found) chk(name, 32'(sel == 0 ? seg0 : seg1), 32'(exp_s));
        else       chk({name, "_timeout"}, 32'(sel == 0 ? an0 : an1), 32'(pat));
    endtask

    task automatic lit_count(input int sel, input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if ((sel == 0 ? an0 : an1) != 3'b111) cnt++;
        end
    endtask

    int  cnt;
    bit  found;

    initial begin
        rst_n = 1'b0; load = 1'b0; bcd_in = '0; blank_mask = '0;
        lz_suppress = 1'b0; blink_en = 1'b0;
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an0), 32'h7);
        chk("rst_seg", 32'(seg0), 32'h7F);
        chk("rst_tick", 32'(tick0), 32'h0);
        rst_n = 1'b1;

        lit_count(0, 12, cnt);
        chk("zero_lit", 32'(cnt), 32'd12);

        show(12'h905, 3'b000, 1'b0);
        check_digit("d905_2", 0, 3'b011, 7'b0000100);
        check_digit("d905_1", 0, 3'b101, 7'b0000001);
        check_digit("d905_0", 0, 3'b110, 7'b0100100);

        show(12'h007, 3'b000, 1'b1);
        check_digit("lz007_0", 0, 3'b110, 7'b0001111);
        lit_count(0, 12, cnt);
        chk("lz007_lit", 32'(cnt), 32'd4);

        show(12'h000, 3'b000, 1'b1);
        check_digit("lz000_0", 0, 3'b110, 7'b0000001);
        lit_count(0, 12, cnt);
        chk("lz000_lit", 32'(cnt), 32'd4);

        show(12'h070, 3'b000, 1'b1);
        check_digit("lz070_1", 0, 3'b101, 7'b0001111);
        check_digit("lz070_0", 0, 3'b110, 7'b0000001);
        lit_count(0, 12, cnt);
        chk("lz070_lit", 32'(cnt), 32'd8);

        show(12'h00A, 3'b000, 1'b0);
        lit_count(0, 12, cnt);
        chk("decA_lit", 32'(cnt), 32'd8);
        check_digit("hexA_0", 1, 3'b110, 7'b0001000);

        show(12'h888, 3'b010, 1'b0);
        lit_count(0, 12, cnt);
        chk("mask_lit", 32'(cnt), 32'd8);
        check_digit("mask_2", 0, 3'b011, 7'b0000000);

        show(12'h888, 3'b000, 1'b0);
        @(negedge clk);
        blink_en = 1'b1;
        repeat (60) @(negedge clk);
        lit_count(0, 48, cnt);
        chk("blink_lit", 32'(cnt), 32'd24);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (an0 == 3'b111) found = 1'b1;
        end
        chk("blink_dark_seen", 32'(found), 32'd1);
        blink_en = 1'b0;
        @(negedge clk);
        chk("blink_off_lit", 32'(an0 != 3'b111), 32'd1);

        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (tick0) found = 1'b1;
        end
        chk("tick_seen", 32'(found), 32'd1);
        @(negedge clk);
        do_load(12'h123, 3'b000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an0), 32'h7);
        chk("async_seg", 32'(seg0), 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_digit("post_rst_0", 0, 3'b110, 7'b0000001);
        lit_count(0, 12, cnt);
        chk("post_rst_lit", 32'(cnt), 32'd12);

        for (int it = 0; it < 60; it++) begin
            logic [11:0] v;
            v = '0;
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 1) == 1) v[4*d +: 4] = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 4) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 1) == 1)
                do_load(v, 3'($urandom_range(0, 7) & ($urandom_range(0, 1) == 1 ? 7 : 0)),
                        1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
